// File: rtl/sqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_seq
//  Description : Sequential unsigned integer square root, one root bit per
//                clock via restoring shift/subtract. Returns floor root,
//                remainder against the floor root, optional round-to-nearest
//                root with saturation flag. Valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqrt_seq #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     radicand,
    input  logic             round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W/2-1:0]   root,
    output logic [W/2:0]     rem,
    output logic             sat
);

    localparam int R  = W / 2;
    localparam int R1 = R + 1;
    localparam int KW = (R > 1) ? $clog2(R) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(R - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    rad_q, rad_d;      // radicand, consumed two MSBs per step
    logic [R-1:0]    proot_q, proot_d;  // partial root
    logic [R-1:0]    prem_q, prem_d;    // partial remainder (< 2^R before last step)
    logic            rnd_q, rnd_d;
    logic [R-1:0]    root_q, root_d;
    logic [R:0]      rem_q, rem_d;
    logic            sat_q, sat_d;

    // One restoring iteration; R+2 bits hold the shifted remainder without loss.
    logic [R+1:0]    rem_shift;
    logic [R+1:0]    trial;
    logic            take;
    logic [R:0]      rem_new;
    logic [R-1:0]    root_new;
    logic            round_up;
    logic [R:0]      root_inc;

    assign rem_shift = {prem_q, rad_q[W-1:W-2]};
    assign trial     = {proot_q, 2'b01};
    assign take      = (rem_shift >= trial);
    // Both branches are below 2^(R+1), so the top bit can be dropped safely.
    assign rem_new   = take ? R1'(rem_shift - trial) : R1'(rem_shift);
    assign root_new  = {proot_q[R-2:0], take};

    // Round up when radicand - r^2 > r, i.e. sqrt lies strictly above r + 0.5.
    assign round_up  = rnd_q && (rem_new > {1'b0, root_new});
    assign root_inc  = {1'b0, root_new} + R1'(1);

    // Next-state and datapath update; every target defaults to hold.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rad_d   = rad_q;
        proot_d = proot_q;
        prem_d  = prem_q;
        rnd_d   = rnd_q;
        root_d  = root_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CALC;
                    rad_d   = radicand;
                    rnd_d   = round;
                    proot_d = '0;
                    prem_d  = '0;
                    k_d     = K_LAST;
                end
            end
            S_CALC: begin
                rad_d   = rad_q << 2;
                proot_d = root_new;
                prem_d  = rem_new[R-1:0];
                k_d     = k_q - KW'(1);
                if (k_q == '0) begin
                    state_d = S_DONE;
                    rem_d   = rem_new;
                    sat_d   = round_up && root_inc[R];
                    if (!round_up) begin
                        root_d = root_new;
                    end else if (root_inc[R]) begin
                        root_d = '1;
                    end else begin
                        root_d = root_inc[R-1:0];
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset drops any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rad_q   <= '0;
            proot_q <= '0;
            prem_q  <= '0;
            rnd_q   <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rad_q   <= rad_d;
            proot_q <= proot_d;
            prem_q  <= prem_d;
            rnd_q   <= rnd_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign root      = root_q;
    assign rem       = rem_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sqrt_seq
//  Description : Self-checking bench for sqrt_seq at W=32 and W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_seq;

    typedef struct packed {
        logic [15:0] root;
        logic [16:0] rem;
        logic        sat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        iv32, ir32, rnd32, ov32, or32, sat32;
    logic [31:0] rad32;
    logic [15:0] root32;
    logic [16:0] rem32;

    logic        iv8, ir8, rnd8, ov8, or8, sat8;
    logic [7:0]  rad8;
    logic [3:0]  root8;
    logic [4:0]  rem8;

    exp_t q32[$];
    exp_t q8[$];
    int   nvec;
    int   nerr;

    sqrt_seq #(.W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .radicand(rad32), .round(rnd32),
        .out_valid(ov32), .out_ready(or32), .root(root32), .rem(rem32), .sat(sat32)
    );

    sqrt_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .radicand(rad8), .round(rnd8),
        .out_valid(ov8), .out_ready(or8), .root(root8), .rem(rem8), .sat(sat8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: greedy bit-by-bit search on r*r <= x, then optional rounding.
    function automatic void ref_sqrt(input logic [31:0] x, input int rw, input bit rnd,
                                     output logic [31:0] root, output logic [32:0] rem,
                                     output bit sat);
        logic [63:0] r;
        logic [63:0] c;
        r = 64'd0;
        for (int b = rw - 1; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= {32'd0, x}) r = c;
        end
        rem  = 33'({32'd0, x} - r * r);
        sat  = 1'b0;
        root = r[31:0];
        if (rnd && ({31'd0, rem} > r)) begin
            r = r + 64'd1;
            if (r == (64'd1 << rw)) begin
                root = 32'((64'd1 << rw) - 64'd1);
                sat  = 1'b1;
            end else begin
                root = r[31:0];
            end
        end
    endfunction

    task automatic run32(input logic [31:0] rad, input bit rnd,
                         input logic [15:0] er, input logic [16:0] em, input bit es);
        exp_t e;
        int   lat;
        int   guard;
        guard = 0;
        while (ir32 !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        iv32 = 1'b1; rad32 = rad; rnd32 = rnd;
        q32.push_back('{root: er, rem: em, sat: es});
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        nvec++;
        if (ir32 !== 1'b0) begin
            nerr++; $display("FAIL w32_accept rad=%h: in_ready=%b want 0", rad, ir32);
        end
        lat = 0;
        while (ov32 !== 1'b1 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        nvec++;
        if (lat != 16) begin
            nerr++; $display("FAIL w32_latency rad=%h: got %0d want 16", rad, lat);
        end
        e = q32.pop_front();
        nvec++;
        if (root32 !== e.root) begin
            nerr++; $display("FAIL w32_root rad=%h rnd=%0d: got %h want %h", rad, rnd, root32, e.root);
        end
        nvec++;
        if (rem32 !== e.rem) begin
            nerr++; $display("FAIL w32_rem rad=%h rnd=%0d: got %h want %h", rad, rnd, rem32, e.rem);
        end
        nvec++;
        if (sat32 !== e.sat) begin
            nerr++; $display("FAIL w32_sat rad=%h rnd=%0d: got %b want %b", rad, rnd, sat32, e.sat);
        end
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({ir32, ov32} !== 2'b10) begin
            nerr++; $display("FAIL w32_release rad=%h: in_ready,out_valid=%b want 10", rad, {ir32, ov32});
        end
    endtask

    task automatic run8(input logic [7:0] rad, input bit rnd,
                        input logic [15:0] er, input logic [16:0] em, input bit es);
        exp_t e;
        int   lat;
        int   guard;
        guard = 0;
        while (ir8 !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        iv8 = 1'b1; rad8 = rad; rnd8 = rnd;
        q8.push_back('{root: er, rem: em, sat: es});
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        nvec++;
        if (lat != 4) begin
            nerr++; $display("FAIL w8_latency rad=%h: got %0d want 4", rad, lat);
        end
        e = q8.pop_front();
        nvec++;
        if ({12'd0, root8} !== e.root || {12'd0, rem8} !== e.rem || sat8 !== e.sat) begin
            nerr++;
            $display("FAIL w8_result rad=%0d rnd=%0d: got root=%0d rem=%0d sat=%b want root=%0d rem=%0d sat=%b",
                     rad, rnd, root8, rem8, sat8, e.root, e.rem, e.sat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({ir32, ov32, root32, rem32, sat32} !== {1'b1, 1'b0, 16'd0, 17'd0, 1'b0}) begin
            nerr++; $display("FAIL reset_w32: rdy=%b vld=%b root=%h rem=%h sat=%b want 1 0 0 0 0",
                             ir32, ov32, root32, rem32, sat32);
        end
        nvec++;
        if ({ir8, ov8, root8, rem8, sat8} !== {1'b1, 1'b0, 4'd0, 5'd0, 1'b0}) begin
            nerr++; $display("FAIL reset_w8: rdy=%b vld=%b root=%h rem=%h sat=%b want 1 0 0 0 0",
                             ir8, ov8, root8, rem8, sat8);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_floor32();
        run32(32'd4, 1'b0, 16'd2, 17'd0, 1'b0);
        run32(32'd64, 1'b0, 16'd8, 17'd0, 1'b0);
        run32(32'h0101_0101, 1'b0, 16'h1008, 17'd193, 1'b0);
        run32(32'd1000, 1'b0, 16'd31, 17'd39, 1'b0);
    endtask

    task automatic test_sweep32();
        logic [31:0] mr;
        logic [32:0] mm;
        bit          ms;
        logic [7:0]  b;
        logic [31:0] x;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            x = {b, b, b, b};
            ref_sqrt(x, 16, 1'b0, mr, mm, ms);
            run32(x, 1'b0, mr[15:0], mm[16:0], ms);
        end
    endtask

    task automatic test_round32();
        logic [31:0] mr;
        logic [32:0] mm;
        bit          ms;
        logic [31:0] k;
        logic [31:0] x;
        run32(32'd6, 1'b1, 16'd2, 17'd2, 1'b0);
        run32(32'd7, 1'b1, 16'd3, 17'd3, 1'b0);
        run32(32'hFFFF_FFFF, 1'b1, 16'hFFFF, 17'h1FFFE, 1'b1);
        run32(32'hFFFF_FFFF, 1'b0, 16'hFFFF, 17'h1FFFE, 1'b0);
        for (int i = 0; i < 12; i++) begin
            k = 32'($urandom_range(1, 65534));
            x = k * k + k;
            run32(x, 1'b1, k[15:0], k[16:0], 1'b0);
            x = x + 32'd1;
            run32(x, 1'b1, 16'(k + 32'd1), k[16:0] + 17'd1, 1'b0);
            x = $urandom();
            ref_sqrt(x, 16, 1'b1, mr, mm, ms);
            run32(x, 1'b1, mr[15:0], mm[16:0], ms);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        or32 = 1'b0;
        while (ir32 !== 1'b1) @(negedge clk);
        iv32 = 1'b1; rad32 = 32'd1000; rnd32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        lat = 0;
        while (ov32 !== 1'b1 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        for (int c = 0; c < 10; c++) begin
            iv32 = 1'b1; rad32 = 32'd16; rnd32 = 1'b1;
            nvec++;
            if ({ov32, ir32, root32, rem32, sat32} !== {1'b1, 1'b0, 16'd31, 17'd39, 1'b0}) begin
                nerr++; $display("FAIL hold cycle %0d: vld=%b rdy=%b root=%0d rem=%0d sat=%b want 1 0 31 39 0",
                                 c, ov32, ir32, root32, rem32, sat32);
            end
            @(posedge clk);
            @(negedge clk);
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({ir32, ov32} !== 2'b10) begin
            nerr++; $display("FAIL hold_release: in_ready,out_valid=%b want 10", {ir32, ov32});
        end
    endtask

    task automatic test_async_reset();
        int seen;
        run32(32'd1000, 1'b0, 16'd31, 17'd39, 1'b0);
        iv32 = 1'b1; rad32 = 32'hFFFF_FFFF; rnd32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({ir32, ov32, root32, rem32, sat32} !== {1'b1, 1'b0, 16'd0, 17'd0, 1'b0}) begin
            nerr++; $display("FAIL async_reset: rdy=%b vld=%b root=%h rem=%h sat=%b want 1 0 0 0 0",
                             ir32, ov32, root32, rem32, sat32);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov32 === 1'b1 || ir32 !== 1'b1) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nerr++; $display("FAIL async_reset_discard: %0d non-idle cycles want 0", seen);
        end
        run32(32'h0101_0101, 1'b0, 16'h1008, 17'd193, 1'b0);
    endtask

    task automatic test_w8();
        logic [31:0] mr;
        logic [32:0] mm;
        bit          ms;
        run8(8'd255, 1'b0, 16'd15, 17'd30, 1'b0);
        run8(8'd255, 1'b1, 16'd15, 17'd30, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 256; x++) begin
                ref_sqrt(32'(x), 4, r[0], mr, mm, ms);
                run8(8'(x), r[0], mr[15:0], mm[16:0], ms);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nerr = 0;
        iv32 = 1'b0; rad32 = '0; rnd32 = 1'b0; or32 = 1'b1;
        iv8  = 1'b0; rad8  = '0; rnd8  = 1'b0; or8  = 1'b1;
        test_reset();
        test_floor32();
        test_sweep32();
        test_round32();
        test_backpressure();
        test_async_reset();
        test_w8();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
